// File: rtl/conv1d_mc.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_mc
// Purpose  : Multi-channel streaming 1-D FIR convolution engine. Samples of
//            CHANNELS time-interleaved channels share one MAC. Each channel
//            has its own KERNEL_SIZE-deep delay line and fill counter.
//            Coefficients are runtime-loadable. The accumulator is rounded
//            (half-up), arithmetically shifted right by SHIFT and saturated
//            to OUT_W bits.
// Ports    : clk, rst_n              - clock, async active-low reset
//            coef_we/addr/data       - coefficient write port
//            flush                   - synchronous clear of stream state
//            valid_in/ready_in/data_in   - input stream (ch0, ch1, ... order)
//            valid_out/ready_out/data_out/ch_out/sat_out - output stream
// Revision : 1.0 - initial release
// ============================================================================
module conv1d_mc #(
    parameter int DATA_W      = 8,
    parameter int COEF_W      = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int CHANNELS    = 2,
    parameter int OUT_W       = 16,
    parameter int SHIFT       = 0
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              coef_we,
    input  logic        [$clog2(KERNEL_SIZE)-1:0]             coef_addr,
    input  logic signed [COEF_W-1:0]                          coef_data,
    input  logic                                              flush,
    input  logic                                              valid_in,
    output logic                                              ready_in,
    input  logic signed [DATA_W-1:0]                          data_in,
    output logic                                              valid_out,
    input  logic                                              ready_out,
    output logic signed [OUT_W-1:0]                           data_out,
    output logic        [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] ch_out,
    output logic                                              sat_out
);

    localparam int AW     = $clog2(KERNEL_SIZE);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FILL_W = $clog2(KERNEL_SIZE + 1);
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(KERNEL_SIZE);
    // One guard bit above the accumulator so adding the rounding constant
    // never wraps, and at least OUT_W+1 bits so the clamp compare is exact.
    localparam int SUM_W  = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;

    localparam logic signed [SUM_W-1:0] ROUND =
        (SHIFT > 0) ? (SUM_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : SUM_W'(0);
    localparam logic signed [SUM_W-1:0] OMAX =
        {{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OMIN =
        {{(SUM_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [DATA_W-1:0] win  [CHANNELS][KERNEL_SIZE];
    logic signed [COEF_W-1:0] coef [KERNEL_SIZE];
    logic        [FILL_W-1:0] fill [CHANNELS];
    logic        [CH_W-1:0]   ch;

    logic                     accept;
    logic                     produce;
    logic        [FILL_W-1:0] fill_next;
    logic signed [ACC_W-1:0]  acc;
    logic signed [SUM_W-1:0]  rounded;
    logic signed [OUT_W-1:0]  result;
    logic                     clip;

    assign ready_in = rst_n && !flush && (!valid_out || ready_out);
    assign accept   = valid_in && ready_in;

    // Fill count after this accept; a result is emitted once the window of
    // the current channel holds KERNEL_SIZE real samples.
    always_comb begin
        fill_next = (fill[ch] == FILL_W'(KERNEL_SIZE)) ? fill[ch] : fill[ch] + FILL_W'(1);
        produce   = accept && (fill_next == FILL_W'(KERNEL_SIZE));
    end

    // MAC over the window as it will look after the shift: tap 0 is the
    // incoming sample, tap k is the stored sample at position k-1.
    always_comb begin
        acc = ACC_W'(data_in) * ACC_W'(coef[0]);
        for (int k = 1; k < KERNEL_SIZE; k++) begin
            acc = acc + ACC_W'(win[ch][k-1]) * ACC_W'(coef[k]);
        end
    end

    always_comb begin
        rounded = (SUM_W'(acc) + ROUND) >>> SHIFT;
        clip    = 1'b0;
        result  = rounded[OUT_W-1:0];
        if (rounded > OMAX) begin
            result = OMAX[OUT_W-1:0];
            clip   = 1'b1;
        end else if (rounded < OMIN) begin
            result = OMIN[OUT_W-1:0];
            clip   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch        <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            ch_out    <= '0;
            sat_out   <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                fill[c] <= '0;
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    win[c][k] <= '0;
                end
            end
            for (int k = 0; k < KERNEL_SIZE; k++) begin
                coef[k] <= (k == 0) ? COEF_W'(1) : COEF_W'(0);
            end
        end else begin
            // Coefficient writes are independent of flush and of the stream.
            if (coef_we && ({1'b0, coef_addr} < (AW + 1)'(KERNEL_SIZE))) begin
                coef[coef_addr] <= coef_data;
            end

            if (flush) begin
                ch        <= '0;
                valid_out <= 1'b0;
                for (int c = 0; c < CHANNELS; c++) begin
                    fill[c] <= '0;
                    for (int k = 0; k < KERNEL_SIZE; k++) begin
                        win[c][k] <= '0;
                    end
                end
            end else begin
                if (accept) begin
                    win[ch][0] <= data_in;
                    for (int k = 1; k < KERNEL_SIZE; k++) begin
                        win[ch][k] <= win[ch][k-1];
                    end
                    fill[ch] <= fill_next;
                    ch       <= (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + CH_W'(1);
                end

                if (produce) begin
                    valid_out <= 1'b1;
                    data_out  <= result;
                    ch_out    <= ch;
                    sat_out   <= clip;
                end else if (valid_out && ready_out) begin
                    valid_out <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv1d_mc
// Purpose  : Directed self-checking bench for conv1d_mc. Two instances share
//            all inputs: dut (SHIFT=0) and dut_s (SHIFT=2, rounding cases).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv1d_mc;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               coef_we   = 1'b0;
    logic        [2:0]  coef_addr = '0;
    logic signed [7:0]  coef_data = '0;
    logic               flush     = 1'b0;
    logic               valid_in  = 1'b0;
    logic signed [7:0]  data_in   = '0;
    logic               ready_out = 1'b1;

    logic               ready_in,  ready_in_s;
    logic               valid_out, valid_out_s;
    logic signed [15:0] data_out,  data_out_s;
    logic        [0:0]  ch_out,    ch_out_s;
    logic               sat_out,   sat_out_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv1d_mc dut (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .flush(flush), .valid_in(valid_in),
        .ready_in(ready_in), .data_in(data_in), .valid_out(valid_out),
        .ready_out(ready_out), .data_out(data_out), .ch_out(ch_out),
        .sat_out(sat_out)
    );

    conv1d_mc #(.SHIFT(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .flush(flush), .valid_in(valid_in),
        .ready_in(ready_in_s), .data_in(data_in), .valid_out(valid_out_s),
        .ready_out(ready_out), .data_out(data_out_s), .ch_out(ch_out_s),
        .sat_out(sat_out_s)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic push(input int val);
        valid_in = 1'b1;
        data_in  = 8'(val);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = 3'(addr);
        coef_data = 8'(val);
        @(posedge clk); #1;
        coef_we   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", valid_out); end
        checks++; if (data_out !== 16'sd0) begin errors++; $display("FAIL rst_data got %0d exp 0", data_out); end
        checks++; if (ch_out !== 1'b0) begin errors++; $display("FAIL rst_ch got %0d exp 0", ch_out); end
        checks++; if (sat_out !== 1'b0) begin errors++; $display("FAIL rst_sat got %0b exp 0", sat_out); end
        checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", ready_in); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b exp 1", ready_in); end
    endtask

    task automatic test_identity();
        int exp_d [4] = '{9, 10, 11, 12};
        int exp_c [4] = '{0, 1, 0, 1};
        for (int i = 1; i <= 12; i++) begin
            push(i);
            checks++; if (valid_out !== (i >= 9)) begin errors++; $display("FAIL ident_valid s%0d got %0b exp %0b", i, valid_out, (i >= 9)); end
            if (i >= 9) begin
                checks++; if (data_out !== 16'(exp_d[i-9])) begin errors++; $display("FAIL ident_data s%0d got %0d exp %0d", i, data_out, exp_d[i-9]); end
                checks++; if (ch_out !== 1'(exp_c[i-9])) begin errors++; $display("FAIL ident_ch s%0d got %0d exp %0d", i, ch_out, exp_c[i-9]); end
                checks++; if (sat_out !== 1'b0) begin errors++; $display("FAIL ident_sat s%0d got %0b exp 0", i, sat_out); end
            end
        end
    endtask

    task automatic test_sum();
        int seq [10] = '{1, 10, 2, 10, 3, 10, 4, 10, 5, 10};
        for (int k = 0; k < 5; k++) write_coef(k, 1);
        do_flush();
        for (int i = 0; i < 10; i++) begin
            push(seq[i]);
            if (i < 8) begin
                checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL sum_warmup s%0d got %0b exp 0", i, valid_out); end
            end
        end
        // After sample 10 the register holds ch1 = 50; ch0 = 15 was seen one cycle earlier.
        checks++; if (data_out !== 16'sd50 || ch_out !== 1'b1) begin errors++; $display("FAIL sum_ch1 got %0d/ch%0d exp 50/ch1", data_out, ch_out); end
    endtask

    task automatic test_sum_ch0();
        int seq [9] = '{1, 10, 2, 10, 3, 10, 4, 10, 5};
        do_flush();
        for (int i = 0; i < 9; i++) push(seq[i]);
        checks++; if (valid_out !== 1'b1 || data_out !== 16'sd15 || ch_out !== 1'b0) begin errors++; $display("FAIL sum_ch0 got v%0b %0d/ch%0d exp v1 15/ch0", valid_out, data_out, ch_out); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) write_coef(k, 127);
        do_flush();
        for (int i = 0; i < 10; i++) begin
            push(127);
            if (i >= 8) begin
                checks++; if (data_out !== 16'sd32767 || sat_out !== 1'b1) begin errors++; $display("FAIL sat_pos s%0d got %0d sat%0b exp 32767 sat1", i, data_out, sat_out); end
            end
        end
        do_flush();
        for (int i = 0; i < 10; i++) begin
            push(-128);
            if (i >= 8) begin
                checks++; if (data_out !== -16'sd32768 || sat_out !== 1'b1) begin errors++; $display("FAIL sat_neg s%0d got %0d sat%0b exp -32768 sat1", i, data_out, sat_out); end
            end
        end
    endtask

    task automatic test_rounding();
        int seq   [12] = '{0, 0, 0, 0, 1, -1, 2, -2, 3, -3, 0, 0};
        int exp_a [4]  = '{6, -6, 5, -5};
        int exp_r [4]  = '{2, -1, 1, -1};
        write_coef(0, 1); write_coef(1, 1); write_coef(2, 1);
        write_coef(3, 0); write_coef(4, 0);
        do_flush();
        for (int i = 0; i < 12; i++) begin
            push(seq[i]);
            if (i >= 8) begin
                checks++; if (data_out !== 16'(exp_a[i-8])) begin errors++; $display("FAIL round_acc s%0d got %0d exp %0d", i, data_out, exp_a[i-8]); end
                checks++; if (data_out_s !== 16'(exp_r[i-8]) || sat_out_s !== 1'b0) begin errors++; $display("FAIL round_shift s%0d got %0d sat%0b exp %0d sat0", i, data_out_s, sat_out_s, exp_r[i-8]); end
            end
        end
    endtask

    task automatic test_backpressure();
        write_coef(1, 0); write_coef(2, 0);
        do_flush();
        for (int i = 1; i <= 9; i++) push(i);
        checks++; if (valid_out !== 1'b1 || data_out !== 16'sd9) begin errors++; $display("FAIL bp_first got v%0b %0d exp v1 9", valid_out, data_out); end
        ready_out = 1'b0;
        valid_in  = 1'b1;
        data_in   = 8'sd10;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (valid_out !== 1'b1 || data_out !== 16'sd9 || ready_in !== 1'b0) begin errors++; $display("FAIL bp_hold c%0d got v%0b %0d rdy%0b exp v1 9 rdy0", c, valid_out, data_out, ready_in); end
        end
        ready_out = 1'b1;
        @(posedge clk); #1;
        checks++; if (valid_out !== 1'b1 || data_out !== 16'sd10 || ch_out !== 1'b1) begin errors++; $display("FAIL bp_next got v%0b %0d/ch%0d exp v1 10/ch1", valid_out, data_out, ch_out); end
        data_in = 8'sd11;
        @(posedge clk); #1;
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1 || data_out !== 16'sd11 || ch_out !== 1'b0) begin errors++; $display("FAIL bp_next2 got v%0b %0d/ch%0d exp v1 11/ch0", valid_out, data_out, ch_out); end
        @(posedge clk); #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", valid_out); end
    endtask

    task automatic test_flush();
        write_coef(0, 2);
        do_flush();
        for (int i = 1; i <= 10; i++) push(i);
        checks++; if (data_out !== 16'sd20 || ch_out !== 1'b1) begin errors++; $display("FAIL flush_pre got %0d/ch%0d exp 20/ch1", data_out, ch_out); end
        flush = 1'b1;
        #1;
        checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", ready_in); end
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", valid_out); end
        for (int i = 21; i <= 29; i++) begin
            push(i);
            checks++; if (valid_out !== (i == 29)) begin errors++; $display("FAIL flush_restart_valid s%0d got %0b exp %0b", i, valid_out, (i == 29)); end
        end
        checks++; if (data_out !== 16'sd58 || ch_out !== 1'b0) begin errors++; $display("FAIL flush_coef_kept got %0d/ch%0d exp 58/ch0", data_out, ch_out); end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0 || data_out !== 16'sd0 || ch_out !== 1'b0 || ready_in !== 1'b0) begin errors++; $display("FAIL rstmid_async got v%0b %0d ch%0d rdy%0b exp v0 0 ch0 rdy0", valid_out, data_out, ch_out, ready_in); end
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b exp 1", ready_in); end
        for (int i = 1; i <= 9; i++) push(i);
        checks++; if (valid_out !== 1'b1 || data_out !== 16'sd9 || ch_out !== 1'b0) begin errors++; $display("FAIL rstmid_identity got v%0b %0d/ch%0d exp v1 9/ch0", valid_out, data_out, ch_out); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_sum();
        test_sum_ch0();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv1d_mc.md
# conv1d_mc

Multi-channel streaming 1-D FIR convolution engine, successor to `conv1d`. Generalised to signed data, runtime-loadable signed coefficients, `CHANNELS` time-interleaved channels with independent delay lines, ready/valid backpressure on both sides, and a rounding right-shift with output saturation. It sits in the level-5 signal-processing datapath between a sample source and downstream consumers that may stall.

## Interface
- `DATA_W`, default 8: signed sample width.
- `COEF_W`, default 8: signed coefficient width.
- `KERNEL_SIZE`, default 5: number of taps; must be at least 2.
- `CHANNELS`, default 2: number of interleaved channels; must be at least 1.
- `OUT_W`, default 16: signed output width after saturation.
- `SHIFT`, default 0: arithmetic right shift applied to the accumulator, with round-half-up.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `coef_we`, input, 1: coefficient write strobe.
- `coef_addr`, input, `$clog2(KERNEL_SIZE)`: tap index. Writes to indices ≥ `KERNEL_SIZE` are ignored.
- `coef_data`, input, `COEF_W`: signed coefficient value.
- `flush`, input, 1: synchronous clear of stream state.
- `valid_in`, input, 1: `data_in` is valid.
- `ready_in`, output, 1: block can accept a sample.
- `data_in`, input, `DATA_W`: signed sample. Channel order is implicit: ch0, ch1, …, ch`CHANNELS`-1, ch0, …
- `valid_out`, output, 1: output register holds a result.
- `ready_out`, input, 1: consumer accepts the result.
- `data_out`, output, `OUT_W`: signed, rounded, saturated result.
- `ch_out`, output, `max(1,$clog2(CHANNELS))`: channel index of `data_out`.
- `sat_out`, output, 1: high when `data_out` was clipped.

## Operation
- Accept happens when `valid_in && ready_in` is true at a rising edge.
  - `ready_in = rst_n && !flush && (!valid_out || ready_out)`.
- Channel counter: selects the channel for each accepted sample. It wraps `CHANNELS`-1 → 0 on accept and resets to 0.
- Each channel has a `KERNEL_SIZE`-deep window. On accept, the sample shifts into its channel's window at position 0 and older samples move up one position.
- Each channel has a fill counter that saturates at `KERNEL_SIZE` and increments on accept.
  - If the count after the increment is `< KERNEL_SIZE`, the sample is absorbed and no output is produced.
  - Otherwise the output register loads the result, `valid_out` goes to 1, and `ch_out` is set to that channel.
- Arithmetic:
  - `acc = Σ c[k]·x[n−k]` for k = 0..`KERNEL_SIZE`-1, full precision, width `DATA_W+COEF_W+$clog2(KERNEL_SIZE)`.
  - `r = (acc + (SHIFT>0 ? 2^(SHIFT−1) : 0)) >>> SHIFT`.
  - `r` is clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. `sat_out` = 1 when the clamp changed the value.
- Coefficients are `KERNEL_SIZE` signed registers.
  - Reset value is the identity: c[0]=1, all others 0.
  - `coef_we` may be asserted at any time. A write takes effect for samples accepted at later edges; a sample accepted on the same edge as a write uses the old value.
  - `flush` does not change coefficients.
- Output register: `valid_out` clears on `valid_out && ready_out` unless a new result loads on the same edge, in which case it stays 1 with the new data.
- `flush` at an edge clears all windows, fill counters, the channel counter and `valid_out`. A pending output is dropped. Flush has priority over accept; `ready_in` is 0 in the flush cycle.

## Timing
- Reset values while `rst_n` is low (asynchronous): `valid_out`=0, `data_out`=0, `ch_out`=0, `sat_out`=0, `ready_in`=0. Windows and counters are 0 and coefficients are the identity.
- Latency: a sample accepted at edge t drives `valid_out`/`data_out` from just after edge t (one register stage; MAC is combinational).
- Throughput is one sample per cycle when `ready_out` is held high.
- While `valid_out && !ready_out`: `data_out`, `ch_out` and `sat_out` are held stable and `ready_in`=0. No sample is lost or duplicated.
- Warm-up: the first output after reset or flush appears on the `(KERNEL_SIZE−1)·CHANNELS+1`-th accepted sample.
- Reset asserted mid-stream discards all state, including coefficients, immediately. After `rst_n` rises, `ready_in` goes to 1 in the same cycle.

## Test plan
- Defaults, identity coefficients, feed 1..12 with `ready_out`=1. The first output appears on sample 9 → outputs 9, 10, 11, 12 with `ch_out` 0, 1, 0, 1. `sat_out` stays 0.
- Load c=[1,1,1,1,1], feed ch0 values 1..5 interleaved with ch1 value 10 on every ch1 slot → ch0 output 15, ch1 output 50.
- Saturation:
  - All coefficients 127 with data 127 → acc 80645 → `data_out`=32767, `sat_out`=1.
  - Data −128 → acc −81280 → `data_out`=−32768, `sat_out`=1.
- Rounding, with `SHIFT`=2 and c=[1,1,1,0,0]:
  - Window giving acc=6 → 2.
  - Window giving acc=−6 → −1.
- Backpressure: drop `ready_out` for 3 cycles while `valid_out`=1.
  - `data_out` is held and `ready_in`=0 for those cycles.
  - After release the output sequence continues with no gaps or duplicates.
- Flush and reset:
  - `flush` after 10 samples → `valid_out`=0 at the next edge. Outputs restart after 9 new samples with `ch_out`=0, and the loaded coefficients are kept.
  - `rst_n` pulsed low mid-stream → outputs go to 0 asynchronously and the identity coefficients are restored.
